// File: rtl/output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : output_port_arbiter
// Description : Round-robin owner of one router output port; forwards whole
//               packets with a 4-phase req/ack flit handshake on both sides.
// Revision    : 1.0
// ============================================================================
module output_port_arbiter #(
    parameter int N        = 32,
    parameter int NIN      = 4,
    parameter int TAIL_BIT = N - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NIN*N-1:0] in_data,
    input  logic [NIN-1:0]   in_req,
    output logic [NIN-1:0]   in_ack,
    output logic [N-1:0]     out_data,
    output logic             out_req,
    input  logic             out_ack,
    output logic [NIN-1:0]   grant_o,
    output logic             busy
);

    localparam int IDX_W = (NIN > 1) ? $clog2(NIN) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ_OUT   = 2'd1,
        ACK_IN    = 2'd2,
        WAIT_FLIT = 2'd3
    } state_t;

    state_t             r_state, w_state;
    logic [IDX_W-1:0]   r_ptr, w_ptr;
    logic [IDX_W-1:0]   r_gnt, w_gnt;
    logic [N-1:0]       r_data, w_data;
    logic               r_out_req, w_out_req;
    logic [NIN-1:0]     r_in_ack, w_in_ack;
    logic [NIN-1:0]     r_grant, w_grant;
    logic               r_busy, w_busy;

    logic [N-1:0]       w_flits [NIN];
    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_idx;

    generate
        for (genvar gi = 0; gi < NIN; gi++) begin : g_unpack
            assign w_flits[gi] = in_data[gi*N +: N];
        end
    endgenerate

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < NIN; i++) begin
            w_idx = IDX_W'((int'(r_ptr) + i) % NIN);
            if (!w_found && in_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_gnt     = r_gnt;
        w_data    = r_data;
        w_out_req = r_out_req;
        w_in_ack  = r_in_ack;
        w_grant   = r_grant;
        w_busy    = r_busy;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt     = w_sel;
                    w_data    = w_flits[w_sel];
                    w_grant   = NIN'(1) << w_sel;
                    w_busy    = 1'b1;
                    w_out_req = 1'b1;
                    w_state   = REQ_OUT;
                end
            end
            REQ_OUT: begin
                if (out_ack) begin
                    w_out_req = 1'b0;
                    w_in_ack  = NIN'(1) << r_gnt;
                    w_state   = ACK_IN;
                end
            end
            ACK_IN: begin
                // Both sides must have returned to zero before the flit closes.
                if (!in_req[r_gnt] && !out_ack) begin
                    w_in_ack = '0;
                    if (r_data[TAIL_BIT]) begin
                        w_grant = '0;
                        w_busy  = 1'b0;
                        w_ptr   = IDX_W'((int'(r_gnt) + 1) % NIN);
                        w_state = IDLE;
                    end else begin
                        w_state = WAIT_FLIT;
                    end
                end
            end
            WAIT_FLIT: begin
                if (in_req[r_gnt]) begin
                    w_data    = w_flits[r_gnt];
                    w_out_req = 1'b1;
                    w_state   = REQ_OUT;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_data    <= '0;
            r_out_req <= 1'b0;
            r_in_ack  <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_gnt     <= w_gnt;
            r_data    <= w_data;
            r_out_req <= w_out_req;
            r_in_ack  <= w_in_ack;
            r_grant   <= w_grant;
            r_busy    <= w_busy;
        end
    end

    assign in_ack   = r_in_ack;
    assign out_data = r_data;
    assign out_req  = r_out_req;
    assign grant_o  = r_grant;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_port_arbiter
// Description : Directed stimulus for output_port_arbiter against a packet
//               level reference model plus literal expectations.
// Revision    : 1.0
// ============================================================================
module tb_output_port_arbiter;

    localparam int N   = 32;
    localparam int NIN = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NIN*N-1:0] in_data = '0;
    logic [NIN-1:0]   in_req = '0;
    logic [NIN-1:0]   in_ack;
    logic [N-1:0]     out_data;
    logic             out_req;
    logic             out_ack = 1'b0;
    logic [NIN-1:0]   grant_o;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int ack_delay = 0;
    int ack_cnt = 0;
    int          log_src[$];
    logic [31:0] log_data[$];

    output_port_arbiter #(.N(N), .NIN(NIN), .TAIL_BIT(N-1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .out_data (out_data),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .grant_o  (grant_o),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [NIN-1:0] v);
        for (int i = 0; i < NIN; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: who owns the port, what flit is offered, which handshake half is open.
    int          m_owner = -1;
    int          m_ptr   = 0;
    logic [31:0] m_flit  = '0;
    bit          m_req   = 0;
    bit          m_ack   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_flit = '0; m_req = 0; m_ack = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NIN; k++) begin
                if (m_owner < 0 && in_req[(m_ptr + k) % NIN]) begin
                    m_owner = (m_ptr + k) % NIN;
                    m_flit  = in_data[m_owner*N +: N];
                    m_req   = 1;
                end
            end
        end else if (m_req) begin
            if (out_ack) begin m_req = 0; m_ack = 1; end
        end else if (m_ack) begin
            if (!in_req[m_owner] && !out_ack) begin
                m_ack = 0;
                if (m_flit[31]) begin
                    m_ptr   = (m_owner + 1) % NIN;
                    m_owner = -1;
                end
            end
        end else if (in_req[m_owner]) begin
            m_flit = in_data[m_owner*N +: N];
            m_req  = 1;
        end
    end

    always @(negedge clk) begin
        check("m_grant",  {28'b0, grant_o}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("m_busy",   {31'b0, busy},    {31'b0, m_owner >= 0});
        check("m_in_ack", {28'b0, in_ack},  m_ack ? (32'd1 << m_owner) : 32'd0);
        check("m_out_req",{31'b0, out_req}, {31'b0, m_req});
        check("m_out_data", out_data, m_flit);
    end

    // Downstream sink: acks after ack_delay cycles, drops ack when out_req falls.
    always @(negedge clk) begin
        if (rst) begin
            out_ack = 1'b0;
            ack_cnt = 0;
        end else if (out_req && !out_ack) begin
            if (ack_cnt >= ack_delay) begin
                out_ack = 1'b1;
                ack_cnt = 0;
                log_src.push_back(oh_idx(grant_o));
                log_data.push_back(out_data);
            end else begin
                ack_cnt++;
            end
        end else if (!out_req && out_ack) begin
            out_ack = 1'b0;
        end
    end

    task automatic wait_ack(input int src, input logic lvl);
        int n = 0;
        while (in_ack[src] !== lvl && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (in_ack[src] !== lvl) begin
            total++;
            bad++;
            $display("FAIL wait_ack timeout: in_ack[%0d] got %b expected %b", src, in_ack[src], lvl);
        end
    endtask

    task automatic send_flit(input int src, input logic [31:0] data);
        @(negedge clk);
        in_data[src*N +: N] = data;
        in_req[src] = 1'b1;
        @(negedge clk);
        wait_ack(src, 1'b1);
        in_req[src] = 1'b0;
        wait_ack(src, 1'b0);
    endtask

    task automatic send_packet(input int src, input int nflits, input logic [31:0] base);
        for (int f = 0; f < nflits; f++)
            send_flit(src, (base + f) | ((f == nflits - 1) ? 32'h8000_0000 : 32'h0));
    endtask

    task automatic check_log(input string name, input int es[$], input logic [31:0] ed[$]);
        check({name, "_len"}, log_src.size(), es.size());
        for (int i = 0; i < es.size(); i++) begin
            if (i < log_src.size()) begin
                check({name, "_src"}, log_src[i], es[i]);
                if (ed.size() > i) check({name, "_data"}, log_data[i], ed[i]);
            end
        end
        log_src.delete();
        log_data.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_grant"},   {28'b0, grant_o}, 32'd0);
        check({name, "_busy"},    {31'b0, busy},    32'd0);
        check({name, "_in_ack"},  {28'b0, in_ack},  32'd0);
        check({name, "_out_req"}, {31'b0, out_req}, 32'd0);
        check({name, "_out_data"}, out_data, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          es[$];
        logic [31:0] ed[$];

        // Reset with every input requesting
        in_req = 4'b1111;
        for (int i = 0; i < NIN; i++) in_data[i*N +: N] = 32'h8000_0010 + i;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        fork
            send_flit(0, 32'h8000_0010);
            send_flit(1, 32'h8000_0011);
            send_flit(2, 32'h8000_0012);
            send_flit(3, 32'h8000_0013);
        join
        repeat (3) @(negedge clk);
        es = '{0, 1, 2, 3};
        ed = '{32'h8000_0010, 32'h8000_0011, 32'h8000_0012, 32'h8000_0013};
        check_log("after_reset", es, ed);

        // Continuous single-flit packets: strict rotation
        fork
            begin send_flit(0, 32'h8000_0020); send_flit(0, 32'h8000_0030); end
            begin send_flit(1, 32'h8000_0021); send_flit(1, 32'h8000_0031); end
            begin send_flit(2, 32'h8000_0022); send_flit(2, 32'h8000_0032); end
            begin send_flit(3, 32'h8000_0023); send_flit(3, 32'h8000_0033); end
        join
        repeat (3) @(negedge clk);
        es = '{0, 1, 2, 3, 0, 1, 2, 3};
        ed = '{32'h8000_0020, 32'h8000_0021, 32'h8000_0022, 32'h8000_0023,
               32'h8000_0030, 32'h8000_0031, 32'h8000_0032, 32'h8000_0033};
        check_log("round_robin", es, ed);

        // Single flit from input 2 with one-cycle latency
        @(negedge clk);
        in_data[2*N +: N] = 32'h8000_0012;
        in_req[2] = 1'b1;
        @(negedge clk);
        check("single_out_req",  {31'b0, out_req}, 32'd1);
        check("single_out_data", out_data, 32'h8000_0012);
        check("single_grant",    {28'b0, grant_o}, 32'h4);
        wait_ack(2, 1'b1);
        in_req[2] = 1'b0;
        wait_ack(2, 1'b0);
        check("single_busy_released", {31'b0, busy}, 32'd0);
        log_src.delete();
        log_data.delete();
        fork
            send_flit(0, 32'h8000_0040);
            send_flit(3, 32'h8000_0043);
        join
        repeat (3) @(negedge clk);
        es = '{3, 0};
        ed = '{32'h8000_0043, 32'h8000_0040};
        check_log("ptr_after_single", es, ed);

        // Packet lock on input 1 while 0 and 3 wait
        fork
            send_packet(1, 3, 32'h0000_0100);
            send_flit(0, 32'h8000_0200);
            send_flit(3, 32'h8000_0300);
        join
        repeat (3) @(negedge clk);
        es = '{1, 1, 1, 3, 0};
        ed = '{32'h0000_0100, 32'h0000_0101, 32'h8000_0102, 32'h8000_0300, 32'h8000_0200};
        check_log("packet_lock", es, ed);

        // Slow downstream
        ack_delay = 10;
        @(negedge clk);
        in_data[2*N +: N] = 32'h8000_0055;
        in_req[2] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("slow_out_req",  {31'b0, out_req}, 32'd1);
            check("slow_out_data", out_data, 32'h8000_0055);
            check("slow_in_ack",   {28'b0, in_ack}, 32'd0);
        end
        wait_ack(2, 1'b1);
        in_req[2] = 1'b0;
        wait_ack(2, 1'b0);
        ack_delay = 0;
        repeat (3) @(negedge clk);
        log_src.delete();
        log_data.delete();

        // Reset pulse while a 4-flit packet waits for its third flit
        send_flit(1, 32'h0000_0A00);
        send_flit(1, 32'h0000_0A01);
        @(negedge clk);
        check("midpkt_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1 check_idle_outputs("midpkt_reset");
        @(negedge clk);
        rst = 1'b0;
        log_src.delete();
        log_data.delete();
        fork
            send_flit(1, 32'h8000_0601);
            send_flit(3, 32'h8000_0603);
        join
        repeat (3) @(negedge clk);
        es = '{1, 3};
        ed = '{32'h8000_0601, 32'h8000_0603};
        check_log("after_midpkt_reset", es, ed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
